// File: rtl/mem_access_unit.sv
// mem_access_unit: requester-side controller for the single-port, word-wide data RAM.
// Accepts byte/half/word loads and stores on a valid/ready request channel, drives the
// RAM write port, reads the RAM's combinational read data, and returns results on a
// valid/ready response channel. Sub-word stores are performed as read-modify-write.
// Optional build macro: MAU_CLEAR_ON_RESET_EN -- zero-fill the whole RAM after reset.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int RAM_DEPTH  = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    requestValid,
    output logic                    requestReady,
    input  logic                    requestWrite,
    input  logic [1:0]              requestSize,
    input  logic                    requestUnsigned,
    input  logic [ADDR_WIDTH+1:0]   requestAddress,
    input  logic [31:0]             requestData,
    output logic                    responseValid,
    input  logic                    responseReady,
    output logic [31:0]             responseData,
    output logic                    responseError,
    output logic [ADDR_WIDTH-1:0]   ramAddress,
    output logic [31:0]             ramDataC,
    output logic                    ramWriteEnable,
    input  logic [31:0]             ramDataOutput
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] RMW_READ = 3'd2;
    localparam logic [2:0] STORE    = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;
    localparam logic [2:0] CLEAR    = 3'd5;

    localparam logic [ADDR_WIDTH:0]   DEPTH_LIMIT = RAM_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD   = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [2:0]            state;
    logic [1:0]            reqSize;
    logic                  reqUnsigned;
    logic [1:0]            reqLane;
    logic [31:0]           reqData;
    logic [31:0]           loadValue;
    logic [31:0]           mergeWord;
    logic [7:0]            laneByte;
    logic [15:0]           laneHalf;
    logic                  requestError;
    logic [ADDR_WIDTH-1:0] requestWord;
    logic                  clearPending;

    // Outputs that are pure functions of the state; the write strobe can therefore
    // never outlive an asynchronous reset.
    assign ramWriteEnable = (state == STORE) || (state == CLEAR);
    assign responseValid  = (state == RESP);
    assign requestReady   = (state == IDLE) && !clearPending;
    assign requestWord    = requestAddress[ADDR_WIDTH+1:2];

    // Classify an incoming request: bad size, misaligned for its size, or beyond the RAM.
    always_comb begin
        requestError = 1'b0;
        case (requestSize)
            2'b00:   requestError = 1'b0;
            2'b01:   requestError = requestAddress[0];
            2'b10:   requestError = (requestAddress[1:0] != 2'b00);
            default: requestError = 1'b1;
        endcase
        if ({1'b0, requestWord} >= DEPTH_LIMIT) begin
            requestError = 1'b1;
        end
    end

    // Lane extraction with sign/zero extension for loads, and lane replacement for
    // sub-word stores; both work on the word currently presented by the RAM.
    always_comb begin
        laneByte  = 8'h00;
        laneHalf  = reqLane[1] ? ramDataOutput[31:16] : ramDataOutput[15:0];
        loadValue = ramDataOutput;
        mergeWord = ramDataOutput;
        case (reqLane)
            2'd0:    laneByte = ramDataOutput[7:0];
            2'd1:    laneByte = ramDataOutput[15:8];
            2'd2:    laneByte = ramDataOutput[23:16];
            default: laneByte = ramDataOutput[31:24];
        endcase
        case (reqSize)
            2'b00: begin
                loadValue = reqUnsigned ? {24'h000000, laneByte} : {{24{laneByte[7]}}, laneByte};
                mergeWord[{reqLane, 3'b000} +: 8] = reqData[7:0];
            end
            2'b01: begin
                loadValue = reqUnsigned ? {16'h0000, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
                mergeWord[{reqLane[1], 4'b0000} +: 16] = reqData[15:0];
            end
            default: begin
                loadValue = ramDataOutput;
                mergeWord = reqData;
            end
        endcase
    end

    // Main sequencer: latches the request at acceptance, walks through the RAM access
    // phases and holds the response until the consumer takes it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            reqSize       <= 2'b00;
            reqUnsigned   <= 1'b0;
            reqLane       <= 2'b00;
            reqData       <= 32'h0;
            responseData  <= 32'h0;
            responseError <= 1'b0;
            ramAddress    <= '0;
            ramDataC      <= 32'h0;
`ifdef MAU_CLEAR_ON_RESET_EN
            clearPending  <= 1'b1;
`else
            clearPending  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (clearPending) begin
                        clearPending <= 1'b0;
                        ramAddress   <= '0;
                        ramDataC     <= 32'h0;
                        state        <= CLEAR;
                    end else if (requestValid) begin
                        reqSize     <= requestSize;
                        reqUnsigned <= requestUnsigned;
                        reqLane     <= requestAddress[1:0];
                        reqData     <= requestData;
                        if (requestError) begin
                            responseData  <= 32'h0;
                            responseError <= 1'b1;
                            state         <= RESP;
                        end else begin
                            ramAddress <= requestWord;
                            if (!requestWrite) begin
                                state <= LOAD;
                            end else if (requestSize == 2'b10) begin
                                ramDataC <= requestData;
                                state    <= STORE;
                            end else begin
                                state <= RMW_READ;
                            end
                        end
                    end
                end
                LOAD: begin
                    responseData  <= loadValue;
                    responseError <= 1'b0;
                    state         <= RESP;
                end
                RMW_READ: begin
                    ramDataC <= mergeWord;
                    state    <= STORE;
                end
                STORE: begin
                    responseData  <= 32'h0;
                    responseError <= 1'b0;
                    state         <= RESP;
                end
                RESP: begin
                    if (responseReady) begin
                        state <= IDLE;
                    end
                end
                CLEAR: begin
                    if (ramAddress == LAST_WORD) begin
                        state <= IDLE;
                    end else begin
                        ramAddress <= ramAddress + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Requester-side controller for the single-port data RAM: the CPU issues byte/half/word loads and stores over a valid/ready request channel, and this block drives the RAM write port (ramAddress, ramDataC, ramWriteEnable) and samples its asynchronous read data (ramDataOutput). Sub-word stores become read-modify-write sequences because the RAM is word-wide only. Results return on a valid/ready response channel.

Parameters:
ADDR_WIDTH, 10, RAM word-address width; byte address is ADDR_WIDTH+2 bits
RAM_DEPTH, 256, number of implemented RAM words; word addresses >= RAM_DEPTH are errors

Ports:
clock  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
requestValid  input  1  request present
requestReady  output  1  block accepts request this cycle
requestWrite  input  1  1 = store, 0 = load
requestSize  input  2  00 byte, 01 half, 10 word, 11 illegal
requestUnsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
requestAddress  input  ADDR_WIDTH+2  byte address, little-endian lanes
requestData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
responseValid  output  1  response present
responseReady  input  1  consumer takes response
responseData  output  32  load result, 0 for stores and errors
responseError  output  1  misaligned, illegal size or out-of-range
ramAddress  output  ADDR_WIDTH  RAM word address
ramDataC  output  32  RAM write data
ramWriteEnable  output  1  RAM write strobe
ramDataOutput  input  32  RAM read data, combinational from ramAddress

Behaviour:
- States: IDLE, LOAD, RMW_READ, STORE, RESP (CLEAR when feature enabled).
- Reset (async, immediate): state IDLE; requestReady 1; responseValid 0, responseData 0, responseError 0; ramAddress 0, ramDataC 0, ramWriteEnable 0. A write strobe in flight is dropped immediately; no RAM write occurs after reset asserts.
- requestReady = 1 only in IDLE. Acceptance = requestValid & requestReady at a rising edge (edge 0); request fields latched then.
- Checks at acceptance: misaligned (half with addr[0]=1, word with addr[1:0]!=0), size 11, or addr[ADDR_WIDTH+1:2] >= RAM_DEPTH -> RESP with responseError=1, responseData=0, no RAM access.
- LOAD: ramAddress = word address, ramWriteEnable 0; edge 1 captures ramDataOutput, extracts lane (byte lane = addr[1:0], half lane = addr[1]), extends per requestUnsigned -> RESP. responseValid high after edge 1.
- Word store -> STORE directly: ramDataC = requestData, ramWriteEnable 1 for exactly one cycle; write at edge 1 -> RESP.
- Sub-word store -> RMW_READ: edge 1 captures ramDataOutput into merge register, replaces selected byte/half lane with requestData low bits -> STORE; write at edge 2 -> RESP. Untouched lanes preserved bit-exactly.
- RESP: responseValid held with stable data/error until responseReady; handshake edge -> IDLE (requestReady rises next cycle; no back-to-back overlap).
- ramWriteEnable is decoded from state only; never high outside STORE/CLEAR.
- ramAddress/ramDataC hold last values when not accessing.

Optional Feature:
MAU_CLEAR_ON_RESET_EN: when defined, reset deassertion enters CLEAR; block writes 0 to word addresses 0..RAM_DEPTH-1, one per cycle (ramWriteEnable 1, ramDataC 0), requestReady 0 throughout, then IDLE after RAM_DEPTH cycles. Reset during CLEAR restarts from address 0. When undefined, reset goes straight to IDLE and RAM contents are untouched.

Test Plan:
- Word store 0xDEADBEEF @ byte addr 0x010, then word load @0x010 -> one ramWriteEnable pulse at ramAddress 4; load responseData 0xDEADBEEF, error 0, valid after edge 1.
- Byte store 0xAA @0x013 over word 0x11223344 -> RMW read then write 0xAA223344; unsigned byte load @0x013 -> 0x000000AA; signed -> 0xFFFFFFAA.
- Half load signed @0x012 from word 0x8001_7FFF -> 0xFFFF8001; @0x010 -> 0x00007FFF.
- Half load @0x011, size 11 @0x000, word load @0x400 (word addr 256) -> responseError 1, responseData 0, ramWriteEnable never asserted.
- responseReady held low 5 cycles in RESP -> responseValid/data stable, requestReady 0, requestValid ignored.
- Assert reset during sub-word store STORE cycle -> ramWriteEnable drops immediately, target word unchanged; with MAU_CLEAR_ON_RESET_EN, 256 zero writes then requestReady 1.
